// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt aggregator: register offsets, CTRL bits, FSM states.
package irq_ctrl_pkg;

   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_MASK   = 2'd1;
   localparam logic [1:0] REG_TYPE   = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int unsigned CTRL_EN  = 0;
   localparam int unsigned CTRL_INV = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      GAP    = 2'd2
   } irq_state_e;

   function automatic logic [7:0] valid_bits(input int unsigned n);
      logic [7:0] v;
      v = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i < n) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Per-source 2-flop synchroniser with history flop; no reset so sources held high across reset give no edge.
module irq_edge_sync (
   input  logic clk_i,
   input  logic irq_i,
   output logic level_o,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic hist_q;
   logic rise_q;

   // rise is registered alongside the history flop so level and rise stay cycle-aligned
   always_ff @(posedge clk_i) begin
      meta_q <= irq_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
      rise_q <= sync_q & ~hist_q;
   end

   assign level_o = hist_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt aggregator: latches up to 8 sources, masks them and drives one line with a forced gap on acknowledge.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter logic [4:0]  BASE_ADDR  = 5'h1c,
   parameter int unsigned NUM_IRQS   = 8,
   parameter logic [7:0]  DFL_TYPE   = 8'hff,
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4:0]          csr_a,
   input  logic [7:0]          csr_di,
   input  logic                csr_we,
   output logic [7:0]          csr_do,
   input  logic [NUM_IRQS-1:0] irq_in,
   output logic                irq_out
);

   localparam logic [7:0] VALID    = valid_bits(NUM_IRQS);
   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

   logic [7:0] lvl;
   logic [7:0] rise;

   for (genvar i = 0; i < 8; i++) begin : g_src
      if (i < NUM_IRQS) begin : g_used
         irq_edge_sync u_sync (
            .clk_i  (clk),
            .irq_i  (irq_in[i]),
            .level_o(lvl[i]),
            .rise_o (rise[i])
         );
      end else begin : g_unused
         assign lvl[i]  = 1'b0;
         assign rise[i] = 1'b0;
      end
   end

   logic [7:0] pending_q, pending_d;
   logic [7:0] mask_q, mask_d;
   logic [7:0] type_q, type_d;
   logic [1:0] ctrl_q, ctrl_d;

   irq_state_e state_q;
   logic [3:0] cnt_q;
   logic       irq_out_q;

   logic [4:0] offset;
   logic       hit;
   logic       wr_status, wr_mask, wr_type, wr_ctrl;
   logic       req, ack;

   assign offset    = csr_a - BASE_ADDR;
   assign hit       = (offset[4:2] == 3'b000);
   assign wr_status = csr_we & hit & (offset[1:0] == REG_STATUS);
   assign wr_mask   = csr_we & hit & (offset[1:0] == REG_MASK);
   assign wr_type   = csr_we & hit & (offset[1:0] == REG_TYPE);
   assign wr_ctrl   = csr_we & hit & (offset[1:0] == REG_CTRL);

   always_comb begin
      mask_d    = mask_q;
      type_d    = type_q;
      ctrl_d    = ctrl_q;
      pending_d = '0;
      if (wr_mask) mask_d = csr_di & VALID;
      if (wr_type) type_d = csr_di & VALID;
      if (wr_ctrl) ctrl_d = csr_di[1:0];
      for (int unsigned i = 0; i < 8; i++) begin
         if (type_q[i]) begin
            pending_d[i] = (pending_q[i] & ~(wr_status & csr_di[i])) | rise[i];
         end else if (wr_type && csr_di[i]) begin
            // level -> edge switch drops the stale level state; a coincident rise still sets
            pending_d[i] = rise[i];
         end else begin
            pending_d[i] = lvl[i];
         end
      end
      pending_d = pending_d & VALID;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         mask_q    <= '0;
         type_q    <= DFL_TYPE & VALID;
         ctrl_q    <= '0;
      end else begin
         pending_q <= pending_d;
         mask_q    <= mask_d;
         type_q    <= type_d;
         ctrl_q    <= ctrl_d;
      end
   end

   assign req = ctrl_q[CTRL_EN] & (|(pending_q & mask_q));
   assign ack = (wr_status && (csr_di != 8'h00)) || wr_mask;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         irq_out_q <= 1'b0;
      end else begin
         irq_out_q <= (state_q == ASSERT) ^ ctrl_q[CTRL_INV];
         case (state_q)
            IDLE: begin
               if (req) state_q <= ASSERT;
            end
            ASSERT: begin
               if (!req || ack) begin
                  state_q <= GAP;
                  cnt_q   <= GAP_LOAD;
               end
            end
            GAP: begin
               if (cnt_q == 4'd0) state_q <= IDLE;
               else cnt_q <= cnt_q - 4'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign irq_out = irq_out_q;

   always_comb begin
      csr_do = '0;
      if (hit) begin
         case (offset[1:0])
            REG_STATUS: csr_do = pending_q;
            REG_MASK:   csr_do = mask_q;
            REG_TYPE:   csr_do = type_q;
            REG_CTRL:   csr_do = {6'b0, ctrl_q};
            default:    csr_do = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register table plus hand-written latency, gap and polarity sequences.
module tb_irq_ctrl;

   localparam logic [4:0] A_STATUS = 5'h1c;
   localparam logic [4:0] A_MASK   = 5'h1d;
   localparam logic [4:0] A_TYPE   = 5'h1e;
   localparam logic [4:0] A_CTRL   = 5'h1f;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] csr_a;
   logic [7:0] csr_di;
   logic       csr_we;
   logic [7:0] csr_do;
   logic [7:0] irq_in;
   logic       irq_out;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic       we;
      logic [4:0] wa;
      logic [7:0] wd;
      logic [4:0] ra;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[10];

   irq_ctrl #(
      .BASE_ADDR (5'h1c),
      .NUM_IRQS  (8),
      .DFL_TYPE  (8'hff),
      .GAP_CYCLES(4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .csr_a  (csr_a),
      .csr_di (csr_di),
      .csr_we (csr_we),
      .csr_do (csr_do),
      .irq_in (irq_in),
      .irq_out(irq_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %02h expected %02h", name, act, exp);
   endtask

   task automatic rd_check(input string name, input logic [4:0] a, input logic [7:0] exp);
      csr_a = a;
      #1;
      check(name, csr_do, exp);
   endtask

   task automatic csr_write(input logic [4:0] a, input logic [7:0] d);
      csr_a  = a;
      csr_di = d;
      csr_we = 1'b1;
      @(posedge clk);
      #1;
      csr_we = 1'b0;
      csr_di = '0;
   endtask

   task automatic do_reset();
      irq_in = '0;
      csr_we = 1'b0;
      rst    = 1'b1;
      tick(3);
      rst    = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      csr_a  = '0;
      csr_di = '0;
      csr_we = 1'b0;
      irq_in = '0;
      tick(1);

      tbl[0] = '{1'b1, A_MASK, 8'ha5, A_MASK,   8'ha5};
      tbl[1] = '{1'b1, A_TYPE, 8'h3c, A_TYPE,   8'h3c};
      tbl[2] = '{1'b1, A_CTRL, 8'hff, A_CTRL,   8'h03};
      tbl[3] = '{1'b1, 5'h1b,  8'hff, A_MASK,   8'ha5};
      tbl[4] = '{1'b1, 5'h00,  8'hff, A_TYPE,   8'h3c};
      tbl[5] = '{1'b0, 5'h00,  8'h00, 5'h1b,    8'h00};
      tbl[6] = '{1'b0, 5'h00,  8'h00, 5'h00,    8'h00};
      tbl[7] = '{1'b0, 5'h00,  8'h00, A_CTRL,   8'h03};
      tbl[8] = '{1'b0, 5'h00,  8'h00, A_STATUS, 8'h00};
      tbl[9] = '{1'b1, A_MASK, 8'h00, A_MASK,   8'h00};

      // reset values
      do_reset();
      check("rst_irq_out", {7'b0, irq_out}, 8'h00);
      rd_check("rst_status", A_STATUS, 8'h00);
      rd_check("rst_mask",   A_MASK,   8'h00);
      rd_check("rst_type",   A_TYPE,   8'hff);
      rd_check("rst_ctrl",   A_CTRL,   8'h00);

      // register access and address decode table
      for (int i = 0; i < 10; i++) begin
         if (tbl[i].we) csr_write(tbl[i].wa, tbl[i].wd);
         rd_check($sformatf("tbl%0d", i), tbl[i].ra, tbl[i].exp);
         if (!tbl[i].we) tick(1);
      end

      // edge pulse latency: PENDING at E3, irq_out at E5
      do_reset();
      csr_write(A_MASK, 8'h01);
      csr_write(A_CTRL, 8'h01);
      irq_in = 8'h01;
      tick(1);
      irq_in = 8'h00;
      tick(2);
      rd_check("pulse_status_e2", A_STATUS, 8'h00);
      tick(1);
      rd_check("pulse_status_e3", A_STATUS, 8'h01);
      tick(1);
      check("pulse_irq_e4", {7'b0, irq_out}, 8'h00);
      tick(1);
      check("pulse_irq_e5", {7'b0, irq_out}, 8'h01);

      // acknowledge with another source pending: gap of GAP_CYCLES+1
      do_reset();
      irq_in = 8'h03;
      tick(1);
      irq_in = 8'h00;
      tick(3);
      rd_check("ack_status_pre", A_STATUS, 8'h03);
      csr_write(A_MASK, 8'h03);
      csr_write(A_CTRL, 8'h01);
      tick(2);
      check("ack_irq_asserted", {7'b0, irq_out}, 8'h01);
      csr_write(A_STATUS, 8'h01);
      check("ack_irq_edge", {7'b0, irq_out}, 8'h01);
      for (int k = 0; k < 5; k++) begin
         tick(1);
         check($sformatf("ack_gap%0d", k), {7'b0, irq_out}, 8'h00);
      end
      tick(1);
      check("ack_reassert", {7'b0, irq_out}, 8'h01);
      rd_check("ack_status_post", A_STATUS, 8'h02);

      // set/clear collision on bit 2, then a plain W1C
      do_reset();
      irq_in = 8'h04;
      tick(1);
      irq_in = 8'h00;
      tick(2);
      csr_write(A_STATUS, 8'h04);
      rd_check("collide_status", A_STATUS, 8'h04);
      csr_write(A_STATUS, 8'h04);
      rd_check("w1c_status", A_STATUS, 8'h00);

      // level source
      do_reset();
      csr_write(A_TYPE, 8'h00);
      csr_write(A_MASK, 8'h08);
      csr_write(A_CTRL, 8'h01);
      irq_in = 8'h08;
      tick(4);
      rd_check("lvl_status", A_STATUS, 8'h08);
      tick(2);
      check("lvl_irq_on", {7'b0, irq_out}, 8'h01);
      csr_write(A_STATUS, 8'hff);
      rd_check("lvl_w1c_ignored", A_STATUS, 8'h08);
      tick(10);
      check("lvl_irq_reassert", {7'b0, irq_out}, 8'h01);
      irq_in = 8'h00;
      tick(5);
      check("lvl_irq_e4", {7'b0, irq_out}, 8'h01);
      tick(1);
      check("lvl_irq_e5", {7'b0, irq_out}, 8'h00);
      rd_check("lvl_status_clr", A_STATUS, 8'h00);
      tick(6);
      check("lvl_irq_idle", {7'b0, irq_out}, 8'h00);

      // polarity, enable and mid-assert reset
      do_reset();
      csr_write(A_CTRL, 8'h02);
      check("pol_irq_w", {7'b0, irq_out}, 8'h00);
      tick(1);
      check("pol_irq_idle", {7'b0, irq_out}, 8'h01);
      csr_write(A_MASK, 8'h01);
      irq_in = 8'h01;
      tick(1);
      irq_in = 8'h00;
      tick(3);
      check("pol_irq_disabled", {7'b0, irq_out}, 8'h01);
      csr_write(A_CTRL, 8'h03);
      tick(1);
      check("pol_irq_w1", {7'b0, irq_out}, 8'h01);
      tick(1);
      check("pol_irq_active", {7'b0, irq_out}, 8'h00);
      rst = 1'b1;
      tick(1);
      check("midrst_irq", {7'b0, irq_out}, 8'h00);
      rd_check("midrst_status", A_STATUS, 8'h00);
      rd_check("midrst_mask",   A_MASK,   8'h00);
      rd_check("midrst_type",   A_TYPE,   8'hff);
      rd_check("midrst_ctrl",   A_CTRL,   8'h00);
      tick(2);
      rst = 1'b0;
      tick(2);
      check("postrst_irq", {7'b0, irq_out}, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
